// File: rtl/add_pkg.sv
// Shared constants and state encoding for the multi-word sequential adder.
package add_pkg;

   localparam int unsigned LEN_DEF  = 16;
   localparam int unsigned MAXW_DEF = 4;

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,
      ST_CHAIN = 1'b1
   } add_state_e;

endpackage

// File: rtl/add_slice.sv
// Combinational LEN-bit adder slice with carry-out and signed overflow.
module add_slice #(
   parameter int unsigned LEN = 16
) (
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] b,
   input  logic           ic,
   output logic [LEN-1:0] y,
   output logic           oc,
   output logic           ovf
);

   logic [LEN:0]   full;
   logic [LEN-1:0] low;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{LEN{1'b0}}, ic};
      // Sum of the lower LEN-1 bits; its top bit is the carry into the sign bit.
      low  = {1'b0, a[LEN-2:0]} + {1'b0, b[LEN-2:0]} + {{(LEN-1){1'b0}}, ic};
      y    = full[LEN-1:0];
      oc   = full[LEN];
      ovf  = low[LEN-1] ^ full[LEN];
   end

endmodule

// File: rtl/add_word_seq.sv
// Streams wide operands word by word through one adder slice, chaining carries between words.
module add_word_seq
   import add_pkg::*;
#(
   parameter int unsigned LEN  = LEN_DEF,
   parameter int unsigned MAXW = MAXW_DEF,
   parameter int unsigned IDXW = $clog2(MAXW)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LEN-1:0]  in_a,
   input  logic [LEN-1:0]  in_b,
   input  logic            in_last,
   input  logic            ic,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LEN-1:0]  out_y,
   output logic [IDXW-1:0] out_idx,
   output logic            out_last,
   output logic            out_oc,
   output logic            out_ovf,
   output logic            out_err
);

   add_state_e    state_q;
   logic          carry_q;
   logic [IDXW-1:0] idx_q;

   logic           accept;
   logic           idx_max;
   logic           last;
   logic           cin;
   logic [LEN-1:0] y;
   logic           oc;
   logic           ovf;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign idx_max  = (idx_q == IDXW'(MAXW - 1));
   // A word is last either by request or because the operand hit MAXW words.
   assign last     = in_last || idx_max;
   assign cin      = (state_q == ST_FIRST) ? ic : carry_q;

   add_slice #(
      .LEN (LEN)
   ) u_slice (
      .a   (in_a),
      .b   (in_b),
      .ic  (cin),
      .y   (y),
      .oc  (oc),
      .ovf (ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FIRST;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_oc    <= 1'b0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_y     <= y;
         out_idx   <= idx_q;
         out_last  <= last;
         out_oc    <= oc;
         out_ovf   <= last ? ovf : 1'b0;
         out_err   <= idx_max && !in_last;
         carry_q   <= oc;
         idx_q     <= last ? '0 : idx_q + IDXW'(1);
         state_q   <= last ? ST_FIRST : ST_CHAIN;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_word_seq.sv
// Self-checking bench for add_word_seq: directed scenarios plus randomized operands vs a wide-integer model.
module tb_add_word_seq;

   localparam int unsigned LEN  = 16;
   localparam int unsigned MAXW = 4;
   localparam int unsigned IDXW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [LEN-1:0]  in_a = '0;
   logic [LEN-1:0]  in_b = '0;
   logic            in_last = 1'b0;
   logic            ic = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [LEN-1:0]  out_y;
   logic [IDXW-1:0] out_idx;
   logic            out_last;
   logic            out_oc;
   logic            out_ovf;
   logic            out_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] obs[$];
   logic [63:0] exp_q[$];
   logic        hold_pending = 1'b0;
   logic [63:0] held = '0;

   always #5 clk = ~clk;

   add_word_seq #(
      .LEN  (LEN),
      .MAXW (MAXW),
      .IDXW (IDXW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .ic        (ic),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_oc    (out_oc),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] pk(input logic [LEN-1:0] y, input logic [IDXW-1:0] idx,
                                      input logic lst, input logic oc, input logic ovf,
                                      input logic err);
      return {40'b0, y, idx, lst, oc, ovf, err};
   endfunction

   function automatic logic [63:0] cur_out();
      return pk(out_y, out_idx, out_last, out_oc, out_ovf, out_err) | (64'(out_valid) << 40);
   endfunction

   // Called at a negedge: drives one cycle of stimulus, records drained words, checks holds.
   task automatic step(input logic v, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                       input logic lst, input logic c, input logic ordy, output logic acc);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_last   = lst;
      ic        = c;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (hold_pending) check("hold", cur_out(), held);
      if (out_valid && out_ready)
         obs.push_back(pk(out_y, out_idx, out_last, out_oc, out_ovf, out_err));
      hold_pending = out_valid && !out_ready;
      held = cur_out();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
   endtask

   task automatic expect_obs(input string tag, input logic [63:0] want[$]);
      check({tag, "_count"}, 64'(obs.size()), 64'(want.size()));
      for (int i = 0; i < want.size() && i < obs.size(); i++)
         check($sformatf("%s_w%0d", tag, i), obs[i], want[i]);
      obs.delete();
   endtask

   // Reference: whole operands as wide integers; per-word carry taken from partial sums.
   task automatic model_operand(input logic [LEN-1:0] aw[MAXW], input logic [LEN-1:0] bw[MAXW],
                                input int n, input logic cin, input logic forced);
      logic [127:0] a_big, b_big, s_big, mask, part;
      int w;
      logic ovf;
      a_big = '0;
      b_big = '0;
      for (int i = 0; i < n; i++) begin
         a_big = a_big | (128'(aw[i]) << (LEN * i));
         b_big = b_big | (128'(bw[i]) << (LEN * i));
      end
      s_big = a_big + b_big + 128'(cin);
      w = LEN * n;
      ovf = (a_big[w-1] == b_big[w-1]) && (s_big[w-1] != a_big[w-1]);
      for (int i = 0; i < n; i++) begin
         mask = (128'(1) << (LEN * (i + 1))) - 128'(1);
         part = (a_big & mask) + (b_big & mask) + 128'(cin);
         exp_q.push_back(pk(s_big[LEN*i +: LEN], IDXW'(i), i == n - 1, part[LEN*(i+1)],
                            (i == n - 1) ? ovf : 1'b0, (i == n - 1) && forced));
      end
   endtask

   initial begin
      logic acc;
      logic [63:0] want[$];
      logic [LEN-1:0] aw[MAXW];
      logic [LEN-1:0] bw[MAXW];
      logic cin0;
      int n;
      logic forced;
      int tries;

      repeat (3) @(negedge clk);
      check("rst_outputs", cur_out(), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-word signed overflow.
      step(1'b1, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b1, acc);
      idle(1'b1);
      want = '{pk(16'h8000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0)};
      expect_obs("ovf1", want);

      // Carry chained across two words.
      step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, acc);
      idle(1'b1);
      want = '{pk(16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0),
               pk(16'h0001, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0)};
      expect_obs("chain", want);

      // IC held high on both words only counts once.
      step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
      idle(1'b1);
      want = '{pk(16'h0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0),
               pk(16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0)};
      expect_obs("ic_once", want);

      // Backpressure: stalled for three cycles, then full-rate streaming.
      step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, acc);
      check("bp_first_acc", 64'(acc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, acc);
         check($sformatf("bp_stall%0d", i), 64'(acc), 64'd0);
      end
      step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, acc);
      check("bp_stream1", 64'(acc), 64'd1);
      step(1'b1, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b1, acc);
      check("bp_stream2", 64'(acc), 64'd1);
      idle(1'b1);
      want = '{pk(16'h0003, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0),
               pk(16'h0030, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0),
               pk(16'h000B, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)};
      expect_obs("bp", want);

      // Overrun: fourth word forced last; fifth starts fresh with IC.
      for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
      idle(1'b1);
      want = '{pk(16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0),
               pk(16'h0000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0),
               pk(16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0),
               pk(16'h0000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1),
               pk(16'h0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
      expect_obs("overrun", want);

      // Reset mid-operand drops the pending word and the carry.
      step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, acc);
      check("rstmid_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", 64'(out_valid), 64'd0);
      hold_pending = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, acc);
      idle(1'b1);
      want = '{pk(16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
      expect_obs("rstmid", want);

      // Randomized operands with random valid gaps and random backpressure.
      exp_q.delete();
      for (int op = 0; op < 150; op++) begin
         n = int'($urandom_range(1, MAXW));
         forced = (n == MAXW) && ($urandom_range(0, 3) == 0);
         for (int i = 0; i < MAXW; i++) begin
            aw[i] = LEN'($urandom);
            bw[i] = LEN'($urandom);
         end
         cin0 = 1'b0;
         for (int i = 0; i < n; i++) begin
            logic c;
            c = 1'($urandom);
            if (i == 0) cin0 = c;
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 100) begin
               if ($urandom_range(0, 3) == 0)
                  step(1'b0, LEN'($urandom), LEN'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) != 0, acc);
               else
                  step(1'b1, aw[i], bw[i], (i == n - 1) && !forced, c,
                       $urandom_range(0, 3) != 0, acc);
               tries++;
            end
            if (!acc) begin
               check("rand_accept_timeout", 64'(tries), 64'd0);
               break;
            end
         end
         model_operand(aw, bw, n, cin0, forced);
      end
      tries = 0;
      while ((out_valid || tries == 0) && tries < 20) begin
         idle(1'b1);
         tries++;
      end
      check("rand_drain", 64'(out_valid), 64'd0);
      expect_obs("rand", exp_q);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
